// File: rtl/downcount_tick_gen_if.sv
// Control/status bundle between a tick-sequence requester and downcount_tick_gen.
interface downcount_tick_gen_if;
  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned COUNT_W  = 4;

  logic                 start;
  logic                 stop;
  logic [PERIOD_W-1:0]  period;
  logic [COUNT_W-1:0]   burst_len;
  logic                 counter_reset;
  logic                 enable;
  logic                 busy;
  logic                 done;
  logic [COUNT_W-1:0]   tick_count;

  // Requester side: issues commands, observes ticks and status.
  modport master (
    output start, stop, period, burst_len,
    input  counter_reset, enable, busy, done, tick_count
  );

  // Tick generator side.
  modport slave (
    input  start, stop, period, burst_len,
    output counter_reset, enable, busy, done, tick_count
  );
endinterface

// File: rtl/downcount_tick_gen.sv
// Tick sequencer for a downstream 4-bit down counter: presets it once, then
// issues evenly spaced enable ticks, either a finite burst or continuously.
// Every output is a flop loaded from the next-state values, so outputs carry
// no combinational path from inputs and clear immediately on reset.
module downcount_tick_gen (
  input  logic                clk,
  input  logic                reset_n,
  downcount_tick_gen_if.slave bus
);
  localparam int unsigned PERIOD_W = 8;
  localparam int unsigned COUNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] prescaler, prescaler_nx;
  logic [PERIOD_W-1:0] period_q, period_nx;
  logic [COUNT_W-1:0]  burst_q, burst_nx;
  logic [COUNT_W-1:0]  tick_q, tick_nx;
  logic                hit;

  logic counter_reset_q, enable_q, busy_q, done_q;
  logic counter_reset_nx, enable_nx, busy_nx, done_nx;

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_nx     = state;
    prescaler_nx = prescaler;
    period_nx    = period_q;
    burst_nx     = burst_q;
    tick_nx      = tick_q;
    hit          = (prescaler == period_q);

    case (state)
      IDLE: begin
        if (bus.start) begin
          period_nx = bus.period;
          burst_nx  = bus.burst_len;
          state_nx  = LOAD;
        end
      end
      LOAD: begin
        prescaler_nx = '0;
        tick_nx      = '0;
        state_nx     = bus.stop ? IDLE : RUN;
      end
      RUN: begin
        if (hit) begin
          prescaler_nx = '0;
          tick_nx      = COUNT_W'(tick_q + COUNT_W'(1));
        end else begin
          prescaler_nx = PERIOD_W'(prescaler + PERIOD_W'(1));
        end
        // A tick decoded alongside stop is still counted above.
        if (bus.stop) begin
          state_nx = IDLE;
        end else if (hit && (burst_q != '0) &&
                     (COUNT_W'(tick_q + COUNT_W'(1)) == burst_q)) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    counter_reset_nx = (state_nx == LOAD);
    busy_nx          = (state_nx == LOAD) || (state_nx == RUN);
    done_nx          = (state_nx == DONE);
    enable_nx        = (state_nx == RUN) && (prescaler_nx == period_nx);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      prescaler       <= '0;
      period_q        <= '0;
      burst_q         <= '0;
      tick_q          <= '0;
      counter_reset_q <= 1'b0;
      enable_q        <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state           <= state_nx;
      prescaler       <= prescaler_nx;
      period_q        <= period_nx;
      burst_q         <= burst_nx;
      tick_q          <= tick_nx;
      counter_reset_q <= counter_reset_nx;
      enable_q        <= enable_nx;
      busy_q          <= busy_nx;
      done_q          <= done_nx;
    end
  end

  assign bus.counter_reset = counter_reset_q;
  assign bus.enable        = enable_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.tick_count    = tick_q;

endmodule

// File: tb/tb_downcount_tick_gen.sv
// Bench for downcount_tick_gen: directed scenarios plus randomized sequences,
// each cycle checked against a sequence-level reference model.
module tb_downcount_tick_gen;
  logic clk;
  logic reset_n;

  downcount_tick_gen_if bus ();

  downcount_tick_gen dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: phase of the sequence, RUN cycle index and ticks issued.
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_DONE = 3;
  int m_mode  = M_IDLE;
  int m_p     = 0;
  int m_b     = 0;
  int m_k     = 0;
  int m_total = 0;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_p = 0; m_b = 0; m_k = 0; m_total = 0;
  endtask

  // One clock edge of the model.
  task automatic model_edge(input bit s, input bit st, input int per, input int bl);
    bit en;
    case (m_mode)
      M_IDLE: if (s) begin m_p = per; m_b = bl; m_mode = M_LOAD; end
      M_LOAD: begin
        m_total = 0; m_k = 0;
        m_mode = st ? M_IDLE : M_RUN;
      end
      M_RUN: begin
        en = ((m_k % (m_p + 1)) == m_p);
        if (en) m_total++;
        m_k++;
        if (st) m_mode = M_IDLE;
        else if (en && m_b != 0 && m_total == m_b) m_mode = M_DONE;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    int exp_en;
    exp_en = (m_mode == M_RUN && (m_k % (m_p + 1)) == m_p) ? 1 : 0;
    chk({tag, ".counter_reset"}, int'(bus.counter_reset), (m_mode == M_LOAD) ? 1 : 0);
    chk({tag, ".enable"}, int'(bus.enable), exp_en);
    chk({tag, ".busy"}, int'(bus.busy), (m_mode == M_LOAD || m_mode == M_RUN) ? 1 : 0);
    chk({tag, ".done"}, int'(bus.done), (m_mode == M_DONE) ? 1 : 0);
    chk({tag, ".tick_count"}, int'(bus.tick_count), m_total % 16);
  endtask

  // Drive inputs on the falling edge, take the rising edge, check 1 time unit later.
  task automatic step(input string tag, input bit s, input bit st, input int per, input int bl);
    @(negedge clk);
    bus.start     = s;
    bus.stop      = st;
    bus.period    = 8'(per);
    bus.burst_len = 4'(bl);
    @(posedge clk);
    model_edge(s, st, per, bl);
    #1;
    check_outputs(tag);
  endtask

  // Advance a started sequence until the model returns to IDLE.
  task automatic run_seq(input string tag, input int max_cyc, input int stop_at,
                         input bit noise, output int dones);
    dones = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (m_mode == M_IDLE) break;
      step(tag, noise ? bit'($urandom % 2) : 1'b0, (i == stop_at),
           noise ? 9 : 0, noise ? 2 : 0);
      if (bus.done) dones++;
    end
    chk({tag, ".end_busy"}, int'(bus.busy), 0);
  endtask

  int dones;
  int p, b, stop_at;

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.period = '0; bus.burst_len = '0;
    reset_n = 1'b0;
    model_reset();
    #3;
    check_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Idle after reset without start.
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 7, 3);

    // period 3, burst 4: ticks at RUN cycles 3,7,11,15 then done.
    step("p3b4.start", 1'b1, 1'b0, 3, 4);
    run_seq("p3b4", 40, -1, 1'b0, dones);
    chk("p3b4.dones", dones, 1);
    chk("p3b4.tick_count", int'(bus.tick_count), 4);

    // Continuous every cycle, wrap past 15, stop in RUN.
    step("p0b0.start", 1'b1, 1'b0, 0, 0);
    run_seq("p0b0", 40, 20, 1'b0, dones);
    chk("p0b0.dones", dones, 0);

    // Single-tick burst.
    step("p0b1.start", 1'b1, 1'b0, 0, 1);
    run_seq("p0b1", 10, -1, 1'b0, dones);
    chk("p0b1.dones", dones, 1);
    chk("p0b1.tick_count", int'(bus.tick_count), 1);

    // Input churn during RUN must not alter spacing or length.
    step("churn.start", 1'b1, 1'b0, 3, 4);
    run_seq("churn", 40, -1, 1'b1, dones);
    chk("churn.dones", dones, 1);
    chk("churn.tick_count", int'(bus.tick_count), 4);

    // Stop during LOAD.
    step("stopload.start", 1'b1, 1'b0, 2, 3);
    run_seq("stopload", 10, 0, 1'b0, dones);
    chk("stopload.dones", dones, 0);
    chk("stopload.tick_count", int'(bus.tick_count), 0);

    // Asynchronous reset mid-RUN.
    step("rst.start", 1'b1, 1'b0, 5, 0);
    for (int i = 0; i < 14; i++) step("rst.run", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst.async");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step("rst.idle", 1'b0, 1'b0, 5, 0);
    step("rst.restart", 1'b1, 1'b0, 1, 2);
    run_seq("rst.restart", 20, -1, 1'b0, dones);
    chk("rst.restart.dones", dones, 1);

    // Randomized sequences.
    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(0, 6));
      b = int'($urandom_range(0, 5));
      if (b == 0) stop_at = int'($urandom_range(0, 40));
      else stop_at = ($urandom % 4 == 0) ? int'($urandom_range(0, 20)) : -1;
      step("rand.start", 1'b1, 1'b0, p, b);
      run_seq("rand", 200, stop_at, bit'($urandom % 2), dones);
      step("rand.gap", 1'b0, bit'($urandom % 2), int'($urandom % 256), int'($urandom % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
